// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//   Command sequencer sitting behind spi_slave. The first byte of every nss
//   frame is a command: bit 7 selects read (1) or write (0), bits 6:0 give the
//   start address. The following bytes are streamed to (write) or fetched
//   from (read) a simple register bus, and the address auto-increments with
//   wrap-around after every transfer.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   nss_i        raw SPI chip select (active low), synchronised here
//   byte_stb_i   one-cycle pulse per completed SPI byte (clk_i domain)
//   rx_data_i    received byte, valid with byte_stb_i
//   tx_data_o    next byte to shift out (to spi_slave data_i)
//   tx_ld_o      one-cycle pulse whenever tx_data_o is updated
//   reg_addr_o   register bus address (held between strobes)
//   reg_wdata_o  register bus write data (held between strobes)
//   reg_we_o     one-cycle write strobe
//   reg_re_o     one-cycle read strobe
//   reg_rdata_i  register read data, sampled in the cycle reg_re_o is high
//   busy_o       high while synchronised nss is low
//   err_o        sticky overrun flag, cleared at the start of the next frame
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int                ADDR_W = 7,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] STATUS = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              nss_i,
  input  logic              byte_stb_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_ld_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RD      = 3'd3;
  localparam logic [2:0] WR      = 3'd4;

  // nss synchroniser and edge detect
  logic nss_meta_q;
  logic nss_s_q;
  logic nss_prev_q;
  logic nss_fall_q;
  logic nss_fall_d;
  logic nss_rise_q;
  logic nss_rise_d;

  // sequencer state
  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W-1:0] reg_addr_q,  reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_we_q,    reg_we_d;
  logic              reg_re_q,    reg_re_d;
  logic [DATA_W-1:0] tx_data_q,   tx_data_d;
  logic              tx_ld_q,     tx_ld_d;
  logic              busy_q,      busy_d;
  logic              err_q,       err_d;

  // Edge detects on the synchronised chip select
  always_comb begin
    nss_fall_d = nss_prev_q & ~nss_s_q;
    nss_rise_d = ~nss_prev_q & nss_s_q;
  end

  // Two-flop synchroniser plus registered edge pulses; the chain resets to the
  // idle-high level so leaving reset never fakes a falling edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nss_meta_q <= 1'b1;
      nss_s_q    <= 1'b1;
      nss_prev_q <= 1'b1;
      nss_fall_q <= 1'b0;
      nss_rise_q <= 1'b0;
    end else begin
      nss_meta_q <= nss_i;
      nss_s_q    <= nss_meta_q;
      nss_prev_q <= nss_s_q;
      nss_fall_q <= nss_fall_d;
      nss_rise_q <= nss_rise_d;
    end
  end

  // Next-state and output decode for the command sequencer
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    tx_data_d   = tx_data_q;
    tx_ld_d     = 1'b0;
    err_d       = err_q;
    busy_d      = ~nss_s_q;

    if (nss_rise_q) begin
      // End of frame beats everything, including a byte strobe in the same
      // cycle and a fetch that has not yet been loaded into tx_data.
      state_d   = IDLE;
      tx_data_d = STATUS;
    end else begin
      case (state_q)
        IDLE: begin
          tx_data_d = STATUS;
          if (nss_fall_q) begin
            state_d = CMD;
            err_d   = 1'b0;
            tx_ld_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end

        CMD: begin
          if (byte_stb_i) begin
            addr_d = rx_data_i[ADDR_W-1:0];
            if (rx_data_i[DATA_W-1]) begin
              reg_re_d   = 1'b1;
              reg_addr_d = rx_data_i[ADDR_W-1:0];
              state_d    = RD_WAIT;
            end else begin
              state_d = WR;
            end
          end else begin
            state_d = CMD;
          end
        end

        RD_WAIT: begin
          // reg_re_o is high in this cycle, so reg_rdata_i is captured here
          tx_data_d = reg_rdata_i;
          tx_ld_d   = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          state_d   = RD;
          if (byte_stb_i) begin
            // Master clocked a byte before the fetch finished: drop it
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end

        RD: begin
          if (byte_stb_i) begin
            reg_re_d   = 1'b1;
            reg_addr_d = addr_q;
            state_d    = RD_WAIT;
          end else begin
            state_d = RD;
          end
        end

        WR: begin
          if (byte_stb_i) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = rx_data_i;
            addr_d      = addr_q + ADDR_W'(1);
          end else begin
            addr_d = addr_q;
          end
          state_d = WR;
        end

        default: begin
          state_d   = IDLE;
          tx_data_d = STATUS;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      tx_data_q   <= STATUS;
      tx_ld_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      tx_data_q   <= tx_data_d;
      tx_ld_q     <= tx_ld_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_ld_o     = tx_ld_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
//   Scenario tasks drive SPI frames as byte strobes and push the bus cycles
//   and transmit loads they should cause onto expectation queues. A monitor
//   pops those queues whenever the DUT raises reg_we_o, reg_re_o or tx_ld_o.
//   The register file is modelled as combinational read data 8'h40 + addr.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       nss;
  logic       stb;
  logic [7:0] rx;
  logic [7:0] tx_data;
  logic       tx_ld;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err;

  int checks;
  int failures;

  wr_t        exp_wr[$];
  logic [6:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  spi_reg_ctrl #(.ADDR_W(7), .DATA_W(8), .STATUS(8'hA5)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .nss_i      (nss),
    .byte_stb_i (stb),
    .rx_data_i  (rx),
    .tx_data_o  (tx_data),
    .tx_ld_o    (tx_ld),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_re_o   (reg_re),
    .reg_rdata_i(reg_rdata),
    .busy_o     (busy),
    .err_o      (err)
  );

  assign reg_rdata = 8'h40 + {1'b0, reg_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare every DUT bus cycle / tx load against the queues
  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (reg_we) begin
          checks++;
          if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write got=%0h:%0h exp=none", reg_addr, reg_wdata);
          end else begin
            w = exp_wr.pop_front();
            if ({reg_addr, reg_wdata} !== {w.a, w.d}) begin
              failures++;
              $display("FAIL write got=%0h:%0h exp=%0h:%0h", reg_addr, reg_wdata, w.a, w.d);
            end
          end
        end
        if (reg_re) begin
          checks++;
          if (exp_rd.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read got=%0h exp=none", reg_addr);
          end else if (reg_addr !== exp_rd[0]) begin
            failures++;
            $display("FAIL read_addr got=%0h exp=%0h", reg_addr, exp_rd.pop_front());
          end else begin
            void'(exp_rd.pop_front());
          end
        end
        if (tx_ld) begin
          checks++;
          if (exp_tx.size() == 0) begin
            failures++;
            $display("FAIL unexpected_tx_ld got=%0h exp=none", tx_data);
          end else if (tx_data !== exp_tx[0]) begin
            failures++;
            $display("FAIL tx_data got=%0h exp=%0h", tx_data, exp_tx.pop_front());
          end else begin
            void'(exp_tx.pop_front());
          end
        end
      end
    end
  endtask

  task automatic start_frame();
    exp_tx.push_back(8'hA5);
    @(posedge clk); #1;
    nss = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    nss = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    stb = 1'b1;
    rx  = b;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nss = 1'b1;
    stb = 1'b0;
    rx  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL reset_tx_data got=%0h exp=a5", tx_data);
    end
    checks++;
    if ({reg_we, reg_re, tx_ld, busy, err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {reg_we, reg_re, tx_ld, busy, err});
    end
    checks++;
    if ({reg_addr, reg_wdata} !== 15'h0000) begin
      failures++;
      $display("FAIL reset_bus got=%0h exp=0", {reg_addr, reg_wdata});
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    exp_wr.push_back('{a: 7'd5, d: 8'h11});
    exp_wr.push_back('{a: 7'd6, d: 8'h22});
    start_frame();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL write_busy got=%b exp=1", busy);
    end
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({reg_addr, reg_wdata} !== {7'd6, 8'h22}) begin
      failures++;
      $display("FAIL write_hold got=%0h:%0h exp=6:22", reg_addr, reg_wdata);
    end
    end_frame();
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      failures++;
      $display("FAIL write_pending got=%0d exp=0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    end
  endtask

  task automatic test_read();
    exp_rd.push_back(7'd3);
    exp_rd.push_back(7'd4);
    exp_rd.push_back(7'd5);
    start_frame();
    exp_tx.push_back(8'h43);
    exp_tx.push_back(8'h44);
    exp_tx.push_back(8'h45);
    send_byte(8'h83);
    send_byte(8'h00);
    send_byte(8'h00);
    end_frame();
    checks++;
    if (tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL read_idle_tx got=%0h exp=a5", tx_data);
    end
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      failures++;
      $display("FAIL read_pending got=%0d exp=0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    end
  endtask

  task automatic test_wrap();
    exp_wr.push_back('{a: 7'd127, d: 8'hAA});
    exp_wr.push_back('{a: 7'd0,   d: 8'hBB});
    start_frame();
    send_byte(8'h7F);
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_frame();
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      failures++;
      $display("FAIL wrap_pending got=%0d exp=0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    end
  endtask

  task automatic test_abort();
    exp_rd.push_back(7'd1);
    start_frame();
    exp_tx.push_back(8'h41);
    send_byte(8'h81);
    end_frame();
    checks++;
    if (tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL abort_tx got=%0h exp=a5", tx_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b exp=0", busy);
    end
    exp_wr.push_back('{a: 7'd2, d: 8'h55});
    start_frame();
    send_byte(8'h02);
    send_byte(8'h55);
    end_frame();
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      failures++;
      $display("FAIL abort_pending got=%0d exp=0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    end
  endtask

  task automatic test_overrun();
    exp_rd.push_back(7'd0);
    start_frame();
    exp_tx.push_back(8'h40);
    // Hold the strobe for two edges: the second lands in the fetch cycle
    @(posedge clk); #1;
    stb = 1'b1;
    rx  = 8'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b exp=1", err);
    end
    end_frame();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b exp=1", err);
    end
    start_frame();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp=0", err);
    end
    end_frame();
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      failures++;
      $display("FAIL overrun_pending got=%0d exp=0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    end
  endtask

  task automatic test_stb_on_rise();
    exp_wr.push_back('{a: 7'd16, d: 8'hAA});
    start_frame();
    send_byte(8'h10);
    send_byte(8'hAA);
    @(posedge clk); #1;
    nss = 1'b1;
    // Two synchroniser flops plus the edge register: the rise pulse is seen
    // by the sequencer at the fourth edge, together with this strobe
    repeat (3) @(posedge clk);
    #1;
    stb = 1'b1;
    rx  = 8'hCC;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({busy, tx_data} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL rise_idle got=%b:%0h exp=0:a5", busy, tx_data);
    end
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      failures++;
      $display("FAIL rise_pending got=%0d exp=0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    nss      = 1'b1;
    stb      = 1'b0;
    rx       = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_abort();
    test_overrun();
    test_stb_on_rise();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
